// File: rtl/hamming_decode_arbiter_if.sv
// Bundle of the two codeword request ports, the decoded output stage and the
// per-channel error counter signals shared between the arbiter and its neighbours.
interface hamming_decode_arbiter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req0_valid;
  logic [6:0]       req0_code;
  logic             req0_ready;
  logic             req1_valid;
  logic [6:0]       req1_code;
  logic             req1_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_chan;
  logic [3:0]       out_data;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt0;
  logic [CNT_W-1:0] err_cnt1;
  logic             clr_cnt;

  modport slave (
    input  req0_valid, req0_code, req1_valid, req1_code, out_ready, clr_cnt,
    output req0_ready, req1_ready, out_valid, out_chan, out_data, out_err,
           err_cnt0, err_cnt1
  );

  modport master (
    output req0_valid, req0_code, req1_valid, req1_code, out_ready, clr_cnt,
    input  req0_ready, req1_ready, out_valid, out_chan, out_data, out_err,
           err_cnt0, err_cnt1
  );
endinterface

// File: rtl/hamming_decode_arbiter.sv
// Two-requester round-robin front end around one shared Hamming(7,4) decoder,
// with a registered output stage and per-channel saturating error counters.
module hamming_decoder (
  input  logic [6:0] i_code,
  output logic [3:0] o_data,
  output logic       o_err
);
  logic [2:0] w_syn;
  logic [6:0] w_fix;

  // Syndrome equals the 1-based position of a single flipped bit.
  always_comb begin
    w_syn[0] = i_code[0] ^ i_code[2] ^ i_code[4] ^ i_code[6];
    w_syn[1] = i_code[1] ^ i_code[2] ^ i_code[5] ^ i_code[6];
    w_syn[2] = i_code[3] ^ i_code[4] ^ i_code[5] ^ i_code[6];
    w_fix    = i_code;
    for (int unsigned i = 0; i < 7; i++) begin
      if (w_syn == 3'(i + 1)) w_fix[i] = ~i_code[i];
    end
    o_data = {w_fix[6], w_fix[5], w_fix[4], w_fix[2]};
    o_err  = |w_syn;
  end
endmodule

module hamming_decode_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  hamming_decode_arbiter_if.slave bus
);
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_t;

  last_t            r_last;
  last_t            w_last_nxt;
  logic             w_can_acc;
  logic             w_grant;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_xfer;
  logic [6:0]       w_code;
  logic [3:0]       w_dec_data;
  logic             w_dec_err;
  logic             r_out_valid;
  logic             r_out_chan;
  logic [3:0]       r_out_data;
  logic             r_out_err;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  assign w_can_acc = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= LAST1;
    else        r_last <= w_last_nxt;
  end

  always_comb begin
    w_last_nxt = r_last;
    if (w_xfer) w_last_nxt = w_grant ? LAST1 : LAST0;
  end

  // Under contention the channel that did not win last time gets the grant.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) w_grant = (r_last == LAST0);
    else if (bus.req1_valid)              w_grant = 1'b1;
    w_rdy0 = rst_n && w_can_acc && bus.req0_valid && !w_grant;
    w_rdy1 = rst_n && w_can_acc && bus.req1_valid &&  w_grant;
    w_xfer = w_rdy0 || w_rdy1;
  end

  assign w_code = w_grant ? bus.req1_code : bus.req0_code;

  hamming_decoder u_dec (
    .i_code (w_code),
    .o_data (w_dec_data),
    .o_err  (w_dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_chan  <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_chan  <= w_grant;
      r_out_data  <= w_dec_data;
      r_out_err   <= w_dec_err;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (bus.clr_cnt) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_xfer && w_dec_err) begin
      if (!w_grant && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if ( w_grant && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_chan   = r_out_chan;
  assign bus.out_data   = r_out_data;
  assign bus.out_err    = r_out_err;
  assign bus.err_cnt0   = r_cnt0;
  assign bus.err_cnt1   = r_cnt1;

  a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rdy0 && w_rdy1));

  a_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (r_out_valid && !bus.out_ready) |=> (r_out_valid && $stable(r_out_data)));
endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed expected words, a monitor
// compares every accepted output word in order.
module tb_hamming_decode_arbiter;
  localparam int unsigned CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hamming_decode_arbiter_if #(.CNT_W(CNT_W)) bus ();

  hamming_decode_arbiter #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       chan;
    logic [3:0] data;
    logic       err;
  } beat_t;

  beat_t      exp_q[$];
  logic [6:0] ch0_q[$];
  logic [6:0] ch1_q[$];
  int checks    = 0;
  int errors    = 0;
  int beats     = 0;
  int flush_req = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit ch, input logic [6:0] code, input logic [3:0] d,
                      input bit e, input bit with_exp);
    beat_t b;
    if (ch) ch1_q.push_back(code);
    else    ch0_q.push_back(code);
    b.chan = ch;
    b.data = d;
    b.err  = e;
    if (with_exp) exp_q.push_back(b);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ch0_q.size() != 0 || ch1_q.size() != 0 ||
            bus.req0_valid || bus.req1_valid) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_outv(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_out_valid"}, int'(bus.out_valid), 1);
  endtask

  initial begin : drv
    logic hs0, hs1;
    int   seen;
    seen = 0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_code  = '0;
    bus.req1_code  = '0;
    forever begin
      @(negedge clk);
      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (seen != flush_req) begin
        seen = flush_req;
        ch0_q.delete();
        ch1_q.delete();
        hs0 = 1'b1;
        hs1 = 1'b1;
      end
      if (hs0) bus.req0_valid = 1'b0;
      if (hs1) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && ch0_q.size() > 0) begin
        bus.req0_code  = ch0_q.pop_front();
        bus.req0_valid = 1'b1;
      end
      if (!bus.req1_valid && ch1_q.size() > 0) begin
        bus.req1_code  = ch1_q.pop_front();
        bus.req1_valid = 1'b1;
      end
    end
  end

  initial begin : mon
    beat_t got, want;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        got = {bus.out_chan, bus.out_data, bus.out_err};
        beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got chan %0d data 0x%0h err %0d, expected no word",
                   got.chan, got.data, got.err);
        end else begin
          want = exp_q.pop_front();
          chk("out_word{chan,data,err}", int'(got), int'(want));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [6:0] sat_code[5];
    logic [3:0] sat_data[5];
    int         b;
    sat_code = '{7'h17, 7'h51, 7'h59, 7'h22, 7'h49};
    sat_data = '{4'h1, 4'hB, 4'h2, 4'h4, 4'h8};
    bus.out_ready = 1'b1;
    bus.clr_cnt   = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_chan",  int'(bus.out_chan), 0);
    chk("rst_out_data",  int'(bus.out_data), 0);
    chk("rst_out_err",   int'(bus.out_err), 0);
    chk("rst_err_cnt0",  int'(bus.err_cnt0), 0);
    chk("rst_err_cnt1",  int'(bus.err_cnt1), 0);
    chk("rst_req0_ready", int'(bus.req0_ready), 0);
    chk("rst_req1_ready", int'(bus.req1_ready), 0);

    push(1'b0, 7'h55, 4'hB, 1'b0, 1'b1);
    @(negedge clk);
    chk("first_req0_ready", int'(bus.req0_ready), 1);
    chk("first_req1_ready", int'(bus.req1_ready), 0);
    wait_drain("first");
    chk("first_err_cnt0", int'(bus.err_cnt0), 0);

    @(negedge clk);
    push(1'b0, 7'h54, 4'hB, 1'b1, 1'b1);
    wait_drain("par_fix");
    chk("par_fix_err_cnt0", int'(bus.err_cnt0), 1);
    chk("par_fix_err_cnt1", int'(bus.err_cnt1), 0);
    @(negedge clk);
    push(1'b1, 7'h15, 4'hB, 1'b1, 1'b1);
    wait_drain("data_fix");
    chk("data_fix_err_cnt1", int'(bus.err_cnt1), 1);

    // Channel 1 was granted last, so contention starts with channel 0.
    @(negedge clk);
    b = beats;
    push(1'b0, 7'h07, 4'h1, 1'b0, 1'b1);
    push(1'b1, 7'h4B, 4'h8, 1'b0, 1'b1);
    push(1'b0, 7'h19, 4'h2, 1'b0, 1'b1);
    push(1'b1, 7'h7F, 4'hF, 1'b0, 1'b1);
    push(1'b0, 7'h2A, 4'h4, 1'b0, 1'b1);
    push(1'b1, 7'h33, 4'h6, 1'b0, 1'b1);
    wait_drain("contend");
    chk("contend_word_count", beats - b, 6);

    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    push(1'b0, 7'h2A, 4'h4, 1'b0, 1'b1);
    push(1'b1, 7'h4B, 4'h8, 1'b0, 1'b1);
    wait_outv("bp");
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_req0_ready", int'(bus.req0_ready), 0);
      chk("bp_req1_ready", int'(bus.req1_ready), 0);
      chk("bp_hold_word", int'({bus.out_valid, bus.out_chan, bus.out_data, bus.out_err}),
          int'({1'b1, 1'b0, 4'h4, 1'b0}));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    b = beats;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_release_back_to_back", beats - b, 2);
    wait_drain("bp");

    @(posedge clk); #1;
    bus.clr_cnt = 1'b1;
    @(posedge clk); #1;
    bus.clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_err_cnt0", int'(bus.err_cnt0), 0);
    chk("clr_err_cnt1", int'(bus.err_cnt1), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      push(1'b0, sat_code[i], sat_data[i], 1'b1, 1'b1);
      wait_drain("sat");
      chk("sat_err_cnt0", int'(bus.err_cnt0), (i < 3) ? i + 1 : 3);
    end

    // Clear is raised before the transfer edge and held across it.
    @(negedge clk);
    push(1'b0, 7'h06, 4'h1, 1'b1, 1'b1);
    @(posedge clk); #1;
    bus.clr_cnt = 1'b1;
    @(posedge clk); #1;
    bus.clr_cnt = 1'b0;
    wait_drain("clr_xfer");
    chk("clr_xfer_err_cnt0", int'(bus.err_cnt0), 0);

    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    push(1'b0, 7'h17, 4'h1, 1'b1, 1'b0);
    push(1'b1, 7'h15, 4'hB, 1'b1, 1'b0);
    wait_outv("pre_rst");
    chk("pre_rst_out_chan", int'(bus.out_chan), 1);
    chk("pre_rst_err_cnt1", int'(bus.err_cnt1), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(bus.out_valid), 0);
    chk("async_rst_err_cnt0", int'(bus.err_cnt0), 0);
    chk("async_rst_err_cnt1", int'(bus.err_cnt1), 0);
    chk("async_rst_req0_ready", int'(bus.req0_ready), 0);
    chk("async_rst_req1_ready", int'(bus.req1_ready), 0);
    @(negedge clk);
    flush_req++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    push(1'b0, 7'h55, 4'hB, 1'b0, 1'b1);
    push(1'b1, 7'h1E, 4'h3, 1'b0, 1'b1);
    wait_drain("post_rst");
    chk("post_rst_err_cnt0", int'(bus.err_cnt0), 0);
    chk("post_rst_err_cnt1", int'(bus.err_cnt1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hamming_decode_arbiter.md
# hamming_decode_arbiter

Shares one combinational `hamming_decoder` instance between two independent codeword requesters. Each requester offers 7-bit codewords on a valid/ready port. A round-robin arbiter grants one requester per cycle and the decoder output is registered into a single output stage that carries the channel ID. Per-channel saturating error counters record how many accepted codewords had a nonzero syndrome. The block sits between the serial/parallel receive front ends and the downstream nibble consumer.

## Interface

Parameters:
- `CNT_W`, default 8: width of each error counter.

Ports:
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req0_valid`  in  1  — channel 0 offers a codeword.
- `req0_code`  in  7  — channel 0 codeword; data bits at positions 6, 5, 4, 2; parity bits at positions 3, 1, 0.
- `req0_ready`  out  1  — channel 0 codeword is accepted this cycle.
- `req1_valid`, `req1_code`, `req1_ready`  — the same three signals for channel 1.
- `out_valid`  out  1  — the output register holds a decoded word.
- `out_ready`  in  1  — the consumer accepts the output word.
- `out_chan`  out  1  — source channel of the output word.
- `out_data`  out  4  — corrected data nibble, ordered {bit6, bit5, bit4, bit2}.
- `out_err`  out  1  — the word had a nonzero syndrome.
- `err_cnt0`  out  CNT_W  — channel 0 error count.
- `err_cnt1`  out  CNT_W  — channel 1 error count.
- `clr_cnt`  in  1  — synchronous clear of both error counters.

## Operation

- Accept condition: `can_acc = !out_valid || out_ready`.
- Arbitration:
  - State: one register `last`, the channel granted most recently. Reset value is 1, so channel 0 wins the first contention.
  - Only one channel valid: that channel is granted.
  - Both channels valid: the channel that is not `last` is granted.
  - `reqN_ready = can_acc && grant==N`. At most one ready is high in any cycle.
  - `reqN_ready` is combinational from both valids and `out_ready`. Requesters must not make valid depend on ready.
- Handshake:
  - A transfer on channel N occurs when `reqN_valid && reqN_ready`.
  - A requester holds valid and code stable until its transfer occurs.
- Decode:
  - The granted codeword is muxed into the shared `hamming_decoder`.
  - Single-bit errors are corrected in the data bits. An error in a parity bit leaves the data unchanged.
  - In both cases `out_err` is 1 when the syndrome is nonzero.
- On a transfer:
  - `out_data`, `out_err` and `out_chan` load from the decoder and grant.
  - `out_valid` is set to 1.
  - `last` is set to the granted channel.
- Without a transfer:
  - If `out_ready` is 1, `out_valid` clears.
  - Otherwise the output register holds, including its data.
- Error counters:
  - On a transfer with a nonzero syndrome, `err_cntN` of the granted channel increments.
  - The counter saturates at 2^CNT_W−1; there is no wrap.
  - `clr_cnt` zeroes both counters. A clear wins over a same-cycle increment, so the result is 0.
- Reset values:
  - `out_valid` = 0, `out_chan` = 0, `out_data` = 0, `out_err` = 0.
  - `err_cnt0` = 0, `err_cnt1` = 0.
  - `last` = 1.
  - Readies are low while `rst_n` is low.
- Reset mid-operation: a word in flight in the output register is discarded. Requesters re-present their codewords after reset.

## Timing

- Latency: 1 cycle. A transfer at edge k gives `out_valid` = 1 with the decoded word after edge k.
- Throughput: one word per cycle while `out_ready` is held at 1.
  - With both channels always valid, grants alternate 0,1,0,1.
- Backpressure: when `out_valid` = 1 and `out_ready` = 0, both readies are 0 and all output fields hold.
- Simultaneous events:
  - Output drain and new accept in the same cycle: `out_valid` stays 1 and the new word replaces the old one; no bubble.
  - `clr_cnt` together with a transfer: the counters read 0 next cycle and the output word is still produced.
- Counter update: visible one cycle after the transfer edge.

## Test plan

- Both channels idle after reset:
  - All outputs are 0.
  - Raise `req0_valid` with code 7'h55 while `out_ready` = 1.
  - Expect `req0_ready` = 1; next cycle `out_valid` = 1, `out_chan` = 0, `out_data` = 4'hB, `out_err` = 0.
- Correction:
  - Channel 1 sends 7'h15 (bit 6 flipped).
  - Expect `out_data` = 4'hB, `out_err` = 1, `err_cnt1` = 1.
  - Channel 0 sends 7'h54 (parity bit 0 flipped).
  - Expect `out_data` = 4'hB, `out_err` = 1, `err_cnt0` = 1.
- Contention:
  - Both valid continuously for 6 cycles with `out_ready` = 1.
  - Expect `out_chan` sequence 0,1,0,1,0,1 and no lost or duplicated words.
- Backpressure:
  - Hold `out_ready` = 0 for 3 cycles with an output word pending.
  - Expect both readies 0 and the output fields stable.
  - Release `out_ready`: the pending word and the next word transfer on back-to-back cycles.
- Saturation and clear:
  - With `CNT_W` = 2, send 5 erroneous words on channel 0.
  - Expect `err_cnt0` to stop at 3.
  - Assert `clr_cnt` in the same cycle as a 6th erroneous transfer; expect `err_cnt0` = 0.
- Async reset mid-stream:
  - Drop `rst_n` between clock edges while `out_valid` = 1.
  - Expect `out_valid` = 0 and both counters 0 immediately.
  - After release, the first contention grants channel 0.
